pcie3_cfg_msg_received_capture: RTL
===================================

// Module: pcie3_cfg_msg_received_capture
// PURPOSE
//  Parametrised successor to the cfg_msg_received wirethrough stub. It forwards the
//  PCIe3 received-message sideband (recd/recd_data/recd_type) through a configurable
//  register pipeline, and captures type-filtered messages into a FWFT FIFO for software
//  or controller readout. FIFO overflow is reported by a sticky flag and a saturating drop counter.
//  It sits between the PCIe3 hard-block cfg_msg_received port and the platform management logic.
// PARAMETERS
//  C_RECD_DATA_WIDTH   8            width of recd_data (>=1)
//  C_RECD_TYPE_WIDTH   5            width of recd_type (1..5)
//  C_PIPE_STAGES       1            register stages on the m_* pass-through path (0..4; 0 = combinational)
//  C_FIFO_DEPTH        16           capture FIFO entries (power of 2, 2..256)
//  C_TYPE_MASK         32'hFFFFFFFF capture-enable bit per type code (bit n enables type n)
//  C_DROP_CNT_WIDTH    16           width of the saturating drop counter
// PORTS
//  aclk          in   1                   clock
//  areset        in   1                   synchronous reset, active-high
//  s_recd        in   1                   message-received strobe, one entry per cycle high
//  s_recd_data   in   C_RECD_DATA_WIDTH   message data byte
//  s_recd_type   in   C_RECD_TYPE_WIDTH   message type code
//  m_recd        out  1                   pipelined copy of s_recd
//  m_recd_data   out  C_RECD_DATA_WIDTH   pipelined copy of s_recd_data
//  m_recd_type   out  C_RECD_TYPE_WIDTH   pipelined copy of s_recd_type
//  f_valid       out  1                   FIFO head entry valid
//  f_ready       in   1                   consumer accepts head entry
//  f_data        out  C_RECD_DATA_WIDTH   FIFO head data
//  f_type        out  C_RECD_TYPE_WIDTH   FIFO head type
//  f_count       out  clog2(DEPTH+1)      current FIFO occupancy
//  ovf           out  1                   sticky overflow flag
//  drop_cnt      out  C_DROP_CNT_WIDTH    entries dropped since last clear (saturates at all-ones)
//  clr_ovf       in   1                   one-cycle pulse: clears ovf and drop_cnt
// BEHAVIOUR
//  Reset: all pipeline regs, m_*, f_valid, f_count, ovf, drop_cnt = 0; FIFO pointers = 0.
//   f_data/f_type read 0 while empty. Reset mid-operation discards all FIFO contents and in-flight stages.
//  Pass-through: m_* = s_* delayed exactly C_PIPE_STAGES cycles. All three fields travel together.
//   No filtering or gating on this path.
//  Capture qualify: push_req = s_recd & C_TYPE_MASK[s_recd_type]. Capture taps the s_* inputs
//   and does not depend on C_PIPE_STAGES.
//  FIFO (first-word fall-through): a push on cycle N makes f_valid high on cycle N+1 when the FIFO was empty.
//   pop = f_valid & f_ready. f_data/f_type change only on pop or on first entry into an empty FIFO.
//  Full: push_req with f_count==DEPTH and no pop -> entry dropped. ovf<=1; drop_cnt<=drop_cnt+1, saturating.
//  Full + pop same cycle: push accepted; f_count unchanged; no drop.
//  Empty + push_req same cycle as f_ready: no pop occurs (f_valid still 0); the entry is stored.
//  Pointers wrap modulo DEPTH; f_count ranges 0..DEPTH.
//  clr_ovf: next cycle ovf=0, drop_cnt=0. If a drop coincides with clr_ovf, the result is ovf=1, drop_cnt=1.
//  No FSM beyond the FIFO occupancy logic; every output is registered except f_data/f_type, which are read from storage at rd_ptr.
// TESTING
//  1) STAGES=2: s_recd=1, data=8'hA5, type=5'h10 for one cycle -> m_recd=1, m_recd_data=A5 and
//     m_recd_type=10 exactly 2 cycles later, for one cycle. With STAGES=0 the copy appears the same cycle.
//  2) Push 3 entries (11/01, 22/02, 33/03) with f_ready=0 -> f_count=3 and the head is 11/01.
//     Then hold f_ready=1 -> entries pop in order over 3 cycles, and f_valid=0 afterwards.
//  3) DEPTH=4, f_ready=0, 6 qualifying strobes -> f_count=4, ovf=1, drop_cnt=2. FIFO holds the first 4 entries.
//  4) Full FIFO: push and pop on the same cycle -> f_count stays 4, drop_cnt unchanged, new entry lands at the tail.
//  5) C_TYPE_MASK=32'h1: strobe type 0 then type 4 -> only type 0 is captured. m_* forwards both.
//  6) Assert areset mid-burst with f_count=3 -> next cycle all outputs are 0 and f_count=0. A drop
//     coinciding with clr_ovf -> ovf=1, drop_cnt=1.

Source files
------------

// File: rtl/pcie3_cfg_msg_received_capture_if.sv
// pcie3_cfg_msg_received_capture_if: received-message sideband, pass-through copy and capture FIFO bundle
interface pcie3_cfg_msg_received_capture_if #(
  parameter int DW  = 8,
  parameter int TW  = 5,
  parameter int CW  = 5,
  parameter int DCW = 16
);
  logic           s_recd;
  logic [DW-1:0]  s_recd_data;
  logic [TW-1:0]  s_recd_type;
  logic           m_recd;
  logic [DW-1:0]  m_recd_data;
  logic [TW-1:0]  m_recd_type;
  logic           f_valid;
  logic           f_ready;
  logic [DW-1:0]  f_data;
  logic [TW-1:0]  f_type;
  logic [CW-1:0]  f_count;
  logic           ovf;
  logic [DCW-1:0] drop_cnt;
  logic           clr_ovf;
  modport master (
    output s_recd, s_recd_data, s_recd_type, f_ready, clr_ovf,
    input  m_recd, m_recd_data, m_recd_type, f_valid, f_data, f_type, f_count, ovf, drop_cnt
  );
  modport slave (
    input  s_recd, s_recd_data, s_recd_type, f_ready, clr_ovf,
    output m_recd, m_recd_data, m_recd_type, f_valid, f_data, f_type, f_count, ovf, drop_cnt
  );
endinterface

// File: rtl/pcie3_cfg_msg_received_capture.sv
// pcie3_cfg_msg_received_capture: pipelined cfg_msg_received pass-through with type-filtered FWFT capture FIFO
module pcie3_cfg_msg_received_capture #(
  parameter int          C_RECD_DATA_WIDTH = 8,
  parameter int          C_RECD_TYPE_WIDTH = 5,
  parameter int          C_PIPE_STAGES     = 1,
  parameter int          C_FIFO_DEPTH      = 16,
  parameter logic [31:0] C_TYPE_MASK       = 32'hFFFFFFFF,
  parameter int          C_DROP_CNT_WIDTH  = 16
) (
  input logic aclk,
  input logic areset,
  pcie3_cfg_msg_received_capture_if.slave bus
);
  localparam int DW  = C_RECD_DATA_WIDTH;
  localparam int TW  = C_RECD_TYPE_WIDTH;
  localparam int W   = 1 + TW + DW;
  localparam int AW  = $clog2(C_FIFO_DEPTH);
  localparam int CW  = $clog2(C_FIFO_DEPTH + 1);
  localparam int DCW = C_DROP_CNT_WIDTH;
  localparam logic [CW-1:0] DEPTH = CW'(C_FIFO_DEPTH);
  logic [W-1:0] s_bus;
  logic [W-1:0] m_bus;
  assign s_bus = {bus.s_recd, bus.s_recd_type, bus.s_recd_data};
  generate
    if (C_PIPE_STAGES == 0) begin : g_comb
      assign m_bus = s_bus;
    end else begin : g_pipe
      logic [W-1:0] pipe_d [C_PIPE_STAGES];
      logic [W-1:0] pipe_q [C_PIPE_STAGES];
      // shift strobe, type and data together one stage per cycle
      always_comb begin
        pipe_d[0] = s_bus;
        for (int i = 1; i < C_PIPE_STAGES; i++) pipe_d[i] = pipe_q[i-1];
      end
      // pipeline registers, flushed on reset so in-flight messages vanish
      always_ff @(posedge aclk)
        for (int i = 0; i < C_PIPE_STAGES; i++) pipe_q[i] <= areset ? '0 : pipe_d[i];
      assign m_bus = pipe_q[C_PIPE_STAGES-1];
    end
  endgenerate
  assign {bus.m_recd, bus.m_recd_type, bus.m_recd_data} = m_bus;
  logic           push_req, pop, full, push, drop;
  logic [AW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]  count_d, count_q;
  logic           valid_d, valid_q;
  logic           ovf_d, ovf_q;
  logic [DCW-1:0] drop_d, drop_q;
  logic [TW+DW-1:0] mem_q [C_FIFO_DEPTH];
  logic [TW+DW-1:0] head;
  // capture qualification, occupancy and overflow bookkeeping; a pop frees room for a same-cycle push
  always_comb begin
    push_req = bus.s_recd & C_TYPE_MASK[bus.s_recd_type];
    pop      = valid_q & bus.f_ready;
    full     = count_q == DEPTH;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = count_d != '0;
    ovf_d    = drop | (ovf_q & ~bus.clr_ovf);
    drop_d   = bus.clr_ovf ? DCW'(drop) : drop_q + DCW'(drop & ~&drop_q);
  end
  // FIFO control state
  always_ff @(posedge aclk)
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  // capture storage; stale contents are hidden by the empty gating on the head
  always_ff @(posedge aclk)
    if (push) mem_q[wr_ptr_q] <= {bus.s_recd_type, bus.s_recd_data};
  assign head         = mem_q[rd_ptr_q];
  assign bus.f_data   = valid_q ? head[DW-1:0] : '0;
  assign bus.f_type   = valid_q ? head[TW+DW-1:DW] : '0;
  assign bus.f_valid  = valid_q;
  assign bus.f_count  = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_q;
endmodule
